// File: rtl/instr_decoder.sv
//==============================================================================
// Module   : instr_decoder
// Brief    : Registered instruction decoder for the ALU, bus, control and
//            optional IO units. Macro IO_DECODE_EN adds the IO unit outputs.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module instr_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] ir,
  input  logic        zf,
  input  logic        cf,
  input  logic        sf,
  input  logic        of,
  output logic [2:0]  alu_op,
  output logic        alu_a_sel,
  output logic [3:0]  alu_s_reg,
  output logic [3:0]  alu_b_reg,
  output logic [3:0]  alu_a_reg,
  output logic [63:0] alu_a_imm,
  output logic [1:0]  bus_op,
  output logic        bus_data_type,
  output logic [3:0]  bus_data_reg,
  output logic [3:0]  bus_addr_reg,
  output logic [16:0] bus_addr_offset,
  output logic [2:0]  cu_op,
  output logic [7:0]  cu_exit_code_imm,
  output logic [25:0] cu_jmp_offset,
  output logic [3:0]  cu_reg0,
  output logic [3:0]  cu_reg1
`ifdef IO_DECODE_EN
  ,
  output logic [1:0]  io_op,
  output logic [7:0]  io_char_imm,
  output logic [3:0]  io_char_reg
`endif
);

  localparam logic [2:0] ALU_NOP = 3'd0, ALU_ADD = 3'd1, ALU_SUB = 3'd2,
                         ALU_MULW = 3'd3, ALU_AND = 3'd4, ALU_SHR = 3'd5,
                         ALU_SHL = 3'd6;
  localparam logic [1:0] BUS_NOP = 2'd0, BUS_FETCH = 2'd1, BUS_STORE = 2'd2;
  localparam logic [2:0] CU_NOP = 3'd0, CU_HALT_IMM = 3'd1, CU_HALT_REG = 3'd2,
                         CU_REL_JMP = 3'd3, CU_ABS_JMP = 3'd4;

  logic [7:0]  op;
  logic        lt;
  logic [2:0]  nxt_alu_op;
  logic        nxt_alu_a_sel;
  logic [3:0]  nxt_alu_b_reg;
  logic [3:0]  nxt_alu_a_reg;
  logic [63:0] nxt_alu_a_imm;
  logic [1:0]  nxt_bus_op;
  logic        nxt_bus_data_type;
  logic [2:0]  nxt_cu_op;

  assign op = ir[31:24];
  assign lt = sf ^ of;

  always_comb begin
    nxt_cu_op = CU_NOP;
    case (op)
      8'h01: nxt_cu_op = CU_HALT_IMM;
      8'h02: nxt_cu_op = CU_HALT_REG;
      8'h05: nxt_cu_op = CU_REL_JMP;
      8'h07: nxt_cu_op = CU_ABS_JMP;
      8'h03: if (!zf)          nxt_cu_op = CU_REL_JMP;
      8'h04: if (zf)           nxt_cu_op = CU_REL_JMP;
      8'h06: if (cf)           nxt_cu_op = CU_REL_JMP;
      8'h08: if (zf || cf)     nxt_cu_op = CU_REL_JMP;
      8'h09: if (!zf && !cf)   nxt_cu_op = CU_REL_JMP;
      8'h0A: if (!cf)          nxt_cu_op = CU_REL_JMP;
      8'h0B: if (!lt)          nxt_cu_op = CU_REL_JMP;
      8'h0C: if (lt)           nxt_cu_op = CU_REL_JMP;
      8'h0D: if (zf || lt)     nxt_cu_op = CU_REL_JMP;
      default: ;
    endcase
  end

  always_comb begin
    nxt_alu_op    = ALU_NOP;
    nxt_alu_a_sel = 1'b0;
    nxt_alu_b_reg = ir[19:16];
    nxt_alu_a_reg = ir[15:12];
    nxt_alu_a_imm = {48'd0, ir[15:0]};
    case (op)
      8'h10, 8'h1C: begin
        // Load-immediate form: wide 20-bit immediate, register operands forced to r0
        nxt_alu_op    = ALU_ADD;
        nxt_alu_a_sel = 1'b1;
        nxt_alu_b_reg = 4'd0;
        nxt_alu_a_reg = 4'd0;
        nxt_alu_a_imm = (op == 8'h1C) ? {{44{ir[19]}}, ir[19:0]} : {44'd0, ir[19:0]};
      end
      8'h11: nxt_alu_op = ALU_ADD;
      8'h12: begin nxt_alu_op = ALU_ADD; nxt_alu_a_sel = 1'b1; end
      8'h13: nxt_alu_op = ALU_SUB;
      8'h14: begin nxt_alu_op = ALU_SUB; nxt_alu_a_sel = 1'b1; end
      8'h15: nxt_alu_op = ALU_MULW;
      8'h16: nxt_alu_op = ALU_AND;
      8'h17: begin nxt_alu_op = ALU_AND; nxt_alu_a_sel = 1'b1; end
      8'h18: begin nxt_alu_op = ALU_SHR; nxt_alu_a_sel = 1'b1; end
      8'h19: begin nxt_alu_op = ALU_SHL; nxt_alu_a_sel = 1'b1; end
      8'h1A: nxt_alu_op = ALU_SHR;
      8'h1B: nxt_alu_op = ALU_SHL;
      default: ;
    endcase
  end

  always_comb begin
    nxt_bus_op        = BUS_NOP;
    nxt_bus_data_type = 1'b0;
    case (op)
      8'h20: nxt_bus_op = BUS_FETCH;
      8'h22: nxt_bus_op = BUS_STORE;
      8'h23: begin nxt_bus_op = BUS_FETCH; nxt_bus_data_type = 1'b1; end
      8'h24: begin nxt_bus_op = BUS_STORE; nxt_bus_data_type = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op           <= ALU_NOP;
      alu_a_sel        <= 1'b0;
      alu_s_reg        <= 4'd0;
      alu_b_reg        <= 4'd0;
      alu_a_reg        <= 4'd0;
      alu_a_imm        <= 64'd0;
      bus_op           <= BUS_NOP;
      bus_data_type    <= 1'b0;
      bus_data_reg     <= 4'd0;
      bus_addr_reg     <= 4'd0;
      bus_addr_offset  <= 17'd0;
      cu_op            <= CU_NOP;
      cu_exit_code_imm <= 8'd0;
      cu_jmp_offset    <= 26'd0;
      cu_reg0          <= 4'd0;
      cu_reg1          <= 4'd0;
    end else if (en) begin
      alu_op           <= nxt_alu_op;
      alu_a_sel        <= nxt_alu_a_sel;
      alu_s_reg        <= ir[23:20];
      alu_b_reg        <= nxt_alu_b_reg;
      alu_a_reg        <= nxt_alu_a_reg;
      alu_a_imm        <= nxt_alu_a_imm;
      bus_op           <= nxt_bus_op;
      bus_data_type    <= nxt_bus_data_type;
      bus_data_reg     <= ir[23:20];
      bus_addr_reg     <= ir[19:16];
      bus_addr_offset  <= {ir[15], ir[15:0]};
      cu_op            <= nxt_cu_op;
      cu_exit_code_imm <= ir[23:16];
      cu_jmp_offset    <= {ir[23:0], 2'b00};
      cu_reg0          <= ir[23:20];
      cu_reg1          <= ir[19:16];
    end
  end

`ifdef IO_DECODE_EN
  logic [1:0] nxt_io_op;

  always_comb begin
    nxt_io_op = 2'd0;
    case (op)
      8'h30: nxt_io_op = 2'd1;
      8'h31: nxt_io_op = 2'd2;
      8'h32: nxt_io_op = 2'd3;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_op       <= 2'd0;
      io_char_imm <= 8'd0;
      io_char_reg <= 4'd0;
    end else if (en) begin
      io_op       <= nxt_io_op;
      io_char_imm <= ir[23:16];
      io_char_reg <= ir[23:20];
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_decoder.sv
//==============================================================================
// Module   : tb_instr_decoder
// Brief    : Self-checking bench for instr_decoder against a behavioural model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_instr_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] ir;
  logic        zf, cf, sf, of;
  logic [2:0]  alu_op;
  logic        alu_a_sel;
  logic [3:0]  alu_s_reg, alu_b_reg, alu_a_reg;
  logic [63:0] alu_a_imm;
  logic [1:0]  bus_op;
  logic        bus_data_type;
  logic [3:0]  bus_data_reg, bus_addr_reg;
  logic [16:0] bus_addr_offset;
  logic [2:0]  cu_op;
  logic [7:0]  cu_exit_code_imm;
  logic [25:0] cu_jmp_offset;
  logic [3:0]  cu_reg0, cu_reg1;
  logic [1:0]  io_op;
  logic [7:0]  io_char_imm;
  logic [3:0]  io_char_reg;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2:0]  alu_op;
    logic        a_sel;
    logic [3:0]  s, b, a;
    logic [63:0] imm;
    logic [1:0]  bus_op;
    logic        dt;
    logic [3:0]  dr, ar;
    logic [16:0] off;
    logic [2:0]  cu_op;
    logic [7:0]  exit_c;
    logic [25:0] jmp;
    logic [3:0]  r0, r1;
    logic [1:0]  io_op;
    logic [7:0]  io_ci;
    logic [3:0]  io_cr;
  } dec_t;

  dec_t exp_q;

  always #5 clk = ~clk;

  instr_decoder dut (
    .clk(clk), .rst(rst), .en(en), .ir(ir),
    .zf(zf), .cf(cf), .sf(sf), .of(of),
    .alu_op(alu_op), .alu_a_sel(alu_a_sel), .alu_s_reg(alu_s_reg),
    .alu_b_reg(alu_b_reg), .alu_a_reg(alu_a_reg), .alu_a_imm(alu_a_imm),
    .bus_op(bus_op), .bus_data_type(bus_data_type), .bus_data_reg(bus_data_reg),
    .bus_addr_reg(bus_addr_reg), .bus_addr_offset(bus_addr_offset),
    .cu_op(cu_op), .cu_exit_code_imm(cu_exit_code_imm), .cu_jmp_offset(cu_jmp_offset),
    .cu_reg0(cu_reg0), .cu_reg1(cu_reg1)
`ifdef IO_DECODE_EN
    , .io_op(io_op), .io_char_imm(io_char_imm), .io_char_reg(io_char_reg)
`endif
  );

`ifndef IO_DECODE_EN
  assign io_op = 2'd0;
  assign io_char_imm = 8'd0;
  assign io_char_reg = 4'd0;
`endif

  function automatic dec_t act();
    return '{alu_op, alu_a_sel, alu_s_reg, alu_b_reg, alu_a_reg, alu_a_imm,
             bus_op, bus_data_type, bus_data_reg, bus_addr_reg, bus_addr_offset,
             cu_op, cu_exit_code_imm, cu_jmp_offset, cu_reg0, cu_reg1,
             io_op, io_char_imm, io_char_reg};
  endfunction

  // Reference decode built directly from the opcode tables and field rules
  function automatic dec_t model(input logic [31:0] w, input logic z, c, s, o);
    dec_t m;
    int   op;
    bit   lt, take;
    op = int'(w[31:24]);
    lt = (s != o);
    m = '0;
    m.exit_c = w[23:16];
    m.jmp    = 26'(w[23:0]) * 26'd4;
    m.r0 = w[23:20];  m.r1 = w[19:16];
    m.s  = w[23:20];  m.b  = w[19:16];  m.a = w[15:12];
    m.imm = 64'(w[15:0]);
    m.dr = w[23:20];  m.ar = w[19:16];
    m.off = w[15] ? 17'(w[15:0]) + 17'h10000 : 17'(w[15:0]);
    case (op)
      'h03: take = !z;            'h04: take = z;
      'h06: take = c;             'h08: take = z | c;
      'h09: take = !z & !c;       'h0A: take = !c;
      'h0B: take = !lt;           'h0C: take = lt;
      'h0D: take = z | lt;        default: take = 0;
    endcase
    if (op == 'h01) m.cu_op = 1;
    else if (op == 'h02) m.cu_op = 2;
    else if (op == 'h05 || take) m.cu_op = 3;
    else if (op == 'h07) m.cu_op = 4;
    if (op inside {'h10, 'h11, 'h12, 'h1C}) m.alu_op = 1;
    if (op inside {'h13, 'h14}) m.alu_op = 2;
    if (op == 'h15) m.alu_op = 3;
    if (op inside {'h16, 'h17}) m.alu_op = 4;
    if (op inside {'h18, 'h1A}) m.alu_op = 5;
    if (op inside {'h19, 'h1B}) m.alu_op = 6;
    m.a_sel = op inside {'h10, 'h12, 'h14, 'h17, 'h18, 'h19, 'h1C};
    if (op == 'h10 || op == 'h1C) begin
      m.b = 0;
      m.a = 0;
      m.imm = 64'(w[19:0]) - ((op == 'h1C && w[19]) ? 64'h100000 : 64'h0);
    end
    if (op inside {'h20, 'h23}) m.bus_op = 1;
    if (op inside {'h22, 'h24}) m.bus_op = 2;
    m.dt = op inside {'h23, 'h24};
`ifdef IO_DECODE_EN
    if (op >= 'h30 && op <= 'h32) m.io_op = 2'(op - 'h30 + 1);
    m.io_ci = w[23:16];
    m.io_cr = w[23:20];
`endif
    return m;
  endfunction

  // Called at a falling edge; applies one rising edge and returns at the next falling edge
  task automatic step(input logic [31:0] w, input logic e, input logic [3:0] f);
    ir = w; en = e; {zf, cf, sf, of} = f;
    @(posedge clk);
    if (e) exp_q = model(w, f[3], f[2], f[1], f[0]);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; ir = 32'h12A5_1234; {zf, cf, sf, of} = 4'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (act() !== dec_t'('0))
      begin errors++; $display("FAIL reset_state: got %h want 0", act()); end
    rst = 1'b0;
    exp_q = '0;
  endtask

  task automatic test_alu_imm();
    step(32'h12A5_1234, 1'b1, 4'b0000);
    checks++;
    if ({alu_op, alu_a_sel, alu_s_reg, alu_b_reg, alu_a_imm, bus_op, cu_op} !==
        {3'd1, 1'b1, 4'hA, 4'h5, 64'h1234, 2'd0, 3'd0})
      begin errors++; $display("FAIL add_imm: got op=%0d sel=%0d s=%h b=%h imm=%h bus=%0d cu=%0d want 1 1 a 5 1234 0 0",
                               alu_op, alu_a_sel, alu_s_reg, alu_b_reg, alu_a_imm, bus_op, cu_op); end
  endtask

  task automatic test_load_imm();
    step(32'h1C3F_FFFF, 1'b1, 4'b0000);
    checks++;
    if ({alu_a_imm, alu_b_reg, alu_s_reg, alu_op} !== {64'hFFFF_FFFF_FFFF_FFFF, 4'h0, 4'h3, 3'd1})
      begin errors++; $display("FAIL sext_imm: got imm=%h b=%h s=%h op=%0d want ffffffffffffffff 0 3 1",
                               alu_a_imm, alu_b_reg, alu_s_reg, alu_op); end
    step(32'h103F_FFFF, 1'b1, 4'b0000);
    checks++;
    if ({alu_a_imm, alu_a_reg} !== {64'h000F_FFFF, 4'h0})
      begin errors++; $display("FAIL zext_imm: got imm=%h a=%h want fffff 0", alu_a_imm, alu_a_reg); end
  endtask

  task automatic test_branch();
    step(32'h0300_0010, 1'b1, 4'b0000);
    checks++;
    if ({cu_op, cu_jmp_offset} !== {3'd3, 26'h40})
      begin errors++; $display("FAIL jnz_taken: got cu=%0d off=%h want 3 40", cu_op, cu_jmp_offset); end
    step(32'h0300_0010, 1'b1, 4'b1000);
    checks++;
    if (cu_op !== 3'd0)
      begin errors++; $display("FAIL jnz_not_taken: got cu=%0d want 0", cu_op); end
    step(32'h0D00_0010, 1'b1, 4'b0010);
    checks++;
    if (cu_op !== 3'd3)
      begin errors++; $display("FAIL jle_taken: got cu=%0d want 3", cu_op); end
  endtask

  task automatic test_bus_hold();
    step(32'h2412_8000, 1'b1, 4'b0000);
    checks++;
    if ({bus_op, bus_data_type, bus_data_reg, bus_addr_reg, bus_addr_offset} !==
        {2'd2, 1'b1, 4'h1, 4'h2, 17'h18000})
      begin errors++; $display("FAIL store_quad: got op=%0d dt=%0d dr=%h ar=%h off=%h want 2 1 1 2 18000",
                               bus_op, bus_data_type, bus_data_reg, bus_addr_reg, bus_addr_offset); end
    step(32'h1199_7777, 1'b0, 4'b1111);
    checks++;
    if ({bus_op, bus_addr_offset, alu_op, cu_exit_code_imm} !== {2'd2, 17'h18000, 3'd0, 8'h12})
      begin errors++; $display("FAIL hold_en0: got bus=%0d off=%h alu=%0d exit=%h want 2 18000 0 12",
                               bus_op, bus_addr_offset, alu_op, cu_exit_code_imm); end
  endtask

  task automatic test_io();
    step(32'h3141_0000, 1'b1, 4'b0000);
    checks++;
`ifdef IO_DECODE_EN
    if ({io_op, io_char_imm, alu_op, bus_op, cu_op} !== {2'd2, 8'h41, 3'd0, 2'd0, 3'd0})
      begin errors++; $display("FAIL putc_imm: got io=%0d ch=%h alu=%0d bus=%0d cu=%0d want 2 41 0 0 0",
                               io_op, io_char_imm, alu_op, bus_op, cu_op); end
`else
    if ({alu_op, bus_op, cu_op} !== 8'd0)
      begin errors++; $display("FAIL io_nop: got alu=%0d bus=%0d cu=%0d want 0 0 0", alu_op, bus_op, cu_op); end
`endif
  endtask

  task automatic test_async_reset();
    step(32'h0712_3456, 1'b1, 4'b0000);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (act() !== dec_t'('0))
      begin errors++; $display("FAIL async_reset: got %h want 0", act()); end
    @(negedge clk);
    rst = 1'b0;
    exp_q = '0;
  endtask

  task automatic test_reset_discard();
    step(32'h2312_0004, 1'b1, 4'b0000);
    ir = 32'h0500_0001; en = 1'b1;
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q = '0;
    step(32'h1555_5555, 1'b0, 4'b0000);
    checks++;
    if (act() !== exp_q)
      begin errors++; $display("FAIL reset_discard: got %h want %h", act(), exp_q); end
    step(32'h0500_0001, 1'b1, 4'b0000);
    checks++;
    if (act() !== exp_q)
      begin errors++; $display("FAIL resume_after_reset: got %h want %h", act(), exp_q); end
  endtask

  task automatic test_random();
    logic [31:0] w;
    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      if ($urandom_range(0, 9) < 8) w[31:24] = 8'($urandom_range(0, 'h35));
      step(w, ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
      checks++;
      if (act() !== exp_q)
        begin errors++; $display("FAIL random[%0d] ir=%h: got %h want %h", i, w, act(), exp_q); end
    end
  endtask

  initial begin
    test_reset();
    test_alu_imm();
    test_load_imm();
    test_branch();
    test_bus_hold();
    test_io();
    test_async_reset();
    test_reset_discard();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
